// File: rtl/common_types_pkg.sv
// Shared CSR address map, Zicsr encodings, mstatus bit positions and the trap sequencer states.
package common_types_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [3:0] {
    StIdle,
    StTEpc,
    StTCause,
    StTStat,
    StTVec,
    StRStat,
    StREpc,
    StCRd,
    StCWr
  } trap_state_t;

  // Immediate forms share the low two funct3 bits with their register forms.
  function automatic logic [31:0] csr_alu(input logic [2:0]  funct3,
                                          input logic [31:0] old,
                                          input logic [31:0] src);
    logic [31:0] res;
    res = old;
    case (funct3[1:0])
      2'b01:   res = src;
      2'b10:   res = old | src;
      2'b11:   res = old & ~src;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Sequences Zicsr read-modify-writes, machine-mode trap entry and MRET onto the
// single-read/single-write CSR file port, issuing fetch redirects on trap/return.
module csr_trap_ctrl
  import common_types_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              op_valid,
  input  logic [2:0]        op_funct3,
  input  logic [CSR_AW-1:0] op_addr,
  input  logic [XLEN-1:0]   op_src,
  output logic              op_done,
  output logic [XLEN-1:0]   op_rdata,
  output logic              op_illegal,
  input  logic              exc_valid,
  input  logic [XLEN-1:0]   exc_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              irq_valid,
  input  logic [4:0]        irq_code,
  input  logic              mret_valid,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              busy,
  output logic [CSR_AW-1:0] csr_raddr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_write,
  output logic [CSR_AW-1:0] csr_waddr,
  output logic [XLEN-1:0]   csr_wdata
);

  trap_state_t       state_q;
  logic [XLEN-1:0]   cause_q, epc_q, src_q, old_q;
  logic              intr_q;
  logic [2:0]        funct3_q;
  logic [CSR_AW-1:0] addr_q;

  logic op_ill;
  logic op_wen;
  logic [XLEN-1:0] vec_base;

  assign busy     = (state_q != StIdle);
  assign op_ill   = (funct3_q[1:0] == 2'b00);
  // Set/clear with a zero operand must not write, so read-only CSRs can be probed.
  assign op_wen   = !op_ill && ((funct3_q[1:0] == 2'b01) || (src_q != '0));
  assign vec_base = {csr_rdata[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      cause_q  <= '0;
      epc_q    <= '0;
      intr_q   <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      old_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // csr_raddr defaults to MSTATUS here, so csr_rdata carries the live MIE bit.
          if (exc_valid) begin
            cause_q <= exc_cause;
            epc_q   <= trap_pc;
            intr_q  <= 1'b0;
            state_q <= StTEpc;
          end else if (irq_valid && csr_rdata[MSTATUS_MIE]) begin
            cause_q <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
            epc_q   <= trap_pc;
            intr_q  <= 1'b1;
            state_q <= StTEpc;
          end else if (mret_valid) begin
            state_q <= StRStat;
          end else if (op_valid) begin
            funct3_q <= op_funct3;
            addr_q   <= op_addr;
            src_q    <= op_src;
            state_q  <= StCRd;
          end
        end
        StTEpc:   state_q <= StTCause;
        StTCause: state_q <= StTStat;
        StTStat:  state_q <= StTVec;
        StTVec:   state_q <= StIdle;
        StRStat:  state_q <= StREpc;
        StREpc:   state_q <= StIdle;
        StCRd: begin
          old_q   <= csr_rdata;
          state_q <= StCWr;
        end
        StCWr:    state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    csr_raddr   = CSR_MSTATUS;
    csr_write   = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    op_done     = 1'b0;
    op_illegal  = 1'b0;
    op_rdata    = '0;
    case (state_q)
      StTEpc: begin
        csr_write = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {epc_q[XLEN-1:2], 2'b00};
      end
      StTCause: begin
        csr_write = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
      end
      StTStat: begin
        csr_write = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = csr_rdata;
        csr_wdata[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
        csr_wdata[MSTATUS_MIE]  = 1'b0;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      StTVec: begin
        csr_raddr = CSR_MTVEC;
        redirect  = 1'b1;
        if (intr_q && (csr_rdata[1:0] == 2'b01)) begin
          redirect_pc = vec_base + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
        end else begin
          redirect_pc = vec_base;
        end
      end
      StRStat: begin
        csr_write = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = csr_rdata;
        csr_wdata[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
        csr_wdata[MSTATUS_MPIE] = 1'b1;
        csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      StREpc: begin
        csr_raddr   = CSR_MEPC;
        redirect    = 1'b1;
        redirect_pc = csr_rdata;
      end
      StCRd: csr_raddr = addr_q;
      StCWr: begin
        op_done    = 1'b1;
        op_illegal = op_ill;
        op_rdata   = op_ill ? '0 : old_q;
        csr_write  = op_wen;
        csr_waddr  = addr_q;
        csr_wdata  = csr_alu(funct3_q, old_q, src_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench: stimulus pushes expected CSR writes, op completions and redirects;
// a negedge monitor pops and compares them against the DUT, including the cycle they appear.
module tb_csr_trap_ctrl;

  localparam int KWr = 0;
  localparam int KDone = 1;
  localparam int KRedir = 2;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
    logic        ill;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_funct3 = '0;
  logic [11:0] op_addr = '0;
  logic [31:0] op_src = '0;
  logic        op_done, op_illegal;
  logic [31:0] op_rdata;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_cause = '0;
  logic [31:0] trap_pc = '0;
  logic        irq_valid = 1'b0;
  logic [4:0]  irq_code = '0;
  logic        mret_valid = 1'b0;
  logic        redirect, busy, csr_write;
  logic [31:0] redirect_pc, csr_rdata, csr_wdata;
  logic [11:0] csr_raddr, csr_waddr;

  logic [31:0] regs [4096];
  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c;

  csr_trap_ctrl dut (
    .clk(clk), .nrst(nrst),
    .op_valid(op_valid), .op_funct3(op_funct3), .op_addr(op_addr), .op_src(op_src),
    .op_done(op_done), .op_rdata(op_rdata), .op_illegal(op_illegal),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .trap_pc(trap_pc),
    .irq_valid(irq_valid), .irq_code(irq_code), .mret_valid(mret_valid),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: combinational read, write on the clock edge.
  assign csr_rdata = regs[csr_raddr];
  always @(posedge clk) if (csr_write) regs[csr_waddr] <= csr_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [11:0] a, input logic [31:0] d,
                      input logic ill, input int cy);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.ill = ill; e.cyc = cy;
    q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [11:0] a, input logic [31:0] d,
                         input logic ill);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h at cyc %0d, expected none",
               kind, a, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d || e.ill !== ill || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind %0d addr %h data %h ill %b cyc %0d, expected kind %0d addr %h data %h ill %b cyc %0d",
                 kind, a, d, ill, cyc, e.kind, e.addr, e.data, e.ill, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (csr_write) observe(KWr, csr_waddr, csr_wdata, 1'b0);
      if (op_done) observe(KDone, 12'h000, op_rdata, op_illegal);
      if (redirect) observe(KRedir, 12'h000, redirect_pc, 1'b0);
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s);
    bit seen;
    seen = 1'b0;
    op_funct3 = f3; op_addr = a; op_src = s; op_valid = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      sync();
      seen = op_done;
    end
    op_valid = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL op_timeout: got no op_done, expected one within 8 cycles");
    end
  endtask

  task automatic wait_redirect();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      sync();
      seen = redirect;
    end
    exc_valid = 1'b0; irq_valid = 1'b0; mret_valid = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL redirect_timeout: got no redirect, expected one within 10 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) regs[i] = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_op_done", {31'b0, op_done}, 32'h0);
    chk("rst_redirect", {31'b0, redirect}, 32'h0);
    chk("rst_csr_write", {31'b0, csr_write}, 32'h0);
    chk("rst_op_rdata", op_rdata, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_raddr", {20'b0, csr_raddr}, 32'h300);
    repeat (2) sync();
    nrst = 1'b1;
    sync();

    // CSRRW to mscratch
    regs[12'h340] = 32'h12;
    c = cyc;
    push(KWr, 12'h340, 32'hDEADBEEF, 1'b0, c + 2);
    push(KDone, 12'h000, 32'h12, 1'b0, c + 2);
    do_op(3'b001, 12'h340, 32'hDEADBEEF);
    sync();

    // CSRRS with zero operand: read only
    regs[12'h300] = 32'h8;
    c = cyc;
    push(KDone, 12'h000, 32'h8, 1'b0, c + 2);
    do_op(3'b010, 12'h300, 32'h0);
    sync();

    // CSRRC clears MIE
    regs[12'h300] = 32'h88;
    c = cyc;
    push(KWr, 12'h300, 32'h80, 1'b0, c + 2);
    push(KDone, 12'h000, 32'h88, 1'b0, c + 2);
    do_op(3'b011, 12'h300, 32'h8);
    sync();

    // CSRRSI with zimm 5
    regs[12'h340] = 32'h10;
    c = cyc;
    push(KWr, 12'h340, 32'h15, 1'b0, c + 2);
    push(KDone, 12'h000, 32'h10, 1'b0, c + 2);
    do_op(3'b110, 12'h340, 32'h5);
    sync();

    // Reserved funct3 100
    c = cyc;
    push(KDone, 12'h000, 32'h0, 1'b1, c + 2);
    do_op(3'b100, 12'h340, 32'h7);
    sync();

    // Synchronous exception, vectored mtvec but exceptions go to base
    regs[12'h305] = 32'h101;
    regs[12'h300] = 32'h8;
    c = cyc;
    push(KWr, 12'h341, 32'h400, 1'b0, c + 1);
    push(KWr, 12'h342, 32'h2, 1'b0, c + 2);
    push(KWr, 12'h300, 32'h1880, 1'b0, c + 3);
    push(KRedir, 12'h000, 32'h100, 1'b0, c + 4);
    exc_cause = 32'h2; trap_pc = 32'h402; exc_valid = 1'b1;
    wait_redirect();
    sync();

    // Interrupt 7, vectored
    regs[12'h300] = 32'h8;
    c = cyc;
    push(KWr, 12'h341, 32'h500, 1'b0, c + 1);
    push(KWr, 12'h342, 32'h80000007, 1'b0, c + 2);
    push(KWr, 12'h300, 32'h1880, 1'b0, c + 3);
    push(KRedir, 12'h000, 32'h11C, 1'b0, c + 4);
    irq_code = 5'd7; trap_pc = 32'h500; irq_valid = 1'b1;
    wait_redirect();
    sync();

    // Interrupt masked by MIE=0
    regs[12'h300] = 32'h0;
    irq_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sync();
      chk("irq_masked_busy", {31'b0, busy}, 32'h0);
    end
    irq_valid = 1'b0;
    sync();

    // MRET
    regs[12'h300] = 32'h1880;
    regs[12'h341] = 32'h400;
    c = cyc;
    push(KWr, 12'h300, 32'h1888, 1'b0, c + 1);
    push(KRedir, 12'h000, 32'h400, 1'b0, c + 2);
    mret_valid = 1'b1;
    wait_redirect();
    sync();

    // Simultaneous exc/mret/op: trap wins; reset lands in T_CAUSE
    regs[12'h300] = 32'h8;
    regs[12'h342] = 32'h0;
    c = cyc;
    push(KWr, 12'h341, 32'h600, 1'b0, c + 1);
    push(KWr, 12'h342, 32'h2, 1'b0, c + 2);
    exc_cause = 32'h2; trap_pc = 32'h600; exc_valid = 1'b1;
    mret_valid = 1'b1;
    op_funct3 = 3'b001; op_addr = 12'h340; op_src = 32'h55; op_valid = 1'b1;
    sync();
    sync();
    nrst = 1'b0;
    exc_valid = 1'b0; mret_valid = 1'b0; op_valid = 1'b0;
    #2;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_write", {31'b0, csr_write}, 32'h0);
    nrst = 1'b1;
    repeat (6) sync();
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_mcause", regs[12'h342], 32'h0);
    chk("post_rst_mstatus", regs[12'h300], 32'h8);
    chk("post_rst_mepc", regs[12'h341], 32'h600);
    chk("queue_drained", q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
